peripheral_bfm_slave_mem_axi4: RTL and testbench
================================================

Name: peripheral_bfm_slave_mem_axi4

Overview:
Parametrised AXI4 slave memory bus-functional model for MPSoC peripheral benches. It supports full bursts (FIXED/INCR/WRAP), byte strobes, ID echo and error responses. Write and read paths are independent state machines over a shared word-addressed array. It replaces fixed 32-bit single-beat slave models in bus and interconnect testbenches.

Parameters:
DATA_WIDTH, 32, data bus width in bits; 32/64/128 only
ADDR_WIDTH, 32, byte address width
ID_WIDTH, 4, transaction ID width
MEM_DEPTH, 256, number of DATA_WIDTH words
BASE_ADDR, 0, byte address mapped to word 0

Ports:
aclk  in  1  clock
aresetn  in  1  reset
awid/arid  in  ID_WIDTH  address IDs
awaddr/araddr  in  ADDR_WIDTH  start byte address
awlen/arlen  in  8  beats minus one
awsize/arsize  in  3  log2 bytes per beat
awburst/arburst  in  2  burst type
awvalid/arvalid  in  1  address valid
awready/arready  out  1  address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wlast  in  1  last write beat
wvalid  in  1  write valid
wready  out  1  write ready
bid  out  ID_WIDTH  response ID
bresp  out  2  write response
bvalid  out  1  response valid
bready  in  1  response ready
rid  out  ID_WIDTH  read ID
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  read valid
rready  in  1  read ready

Behaviour:
- Reset: aresetn synchronous, active-low; clock aclk. All outputs registered and 0 in reset: awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast. Memory contents are not reset. Reset mid-burst aborts the burst; both FSMs return to IDLE.
- Write FSM W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready=1 (first cycle after reset release). AW handshake latches id/addr/len/size/burst, clears beat counter and error flag, sets awready=0 and wready=1.
  - W_DATA: each W handshake writes the enabled byte lanes of the current word at that edge, then advances the address.
  - W_DATA exit: a handshake with wlast=1, or with beat counter==len, moves to W_RESP. The next cycle drives wready=0, bvalid=1, bid=latched id.
  - W_RESP: on bready, bvalid=0 and return to W_IDLE (awready=1 next cycle).
- Read FSM R_IDLE -> R_DATA.
  - R_IDLE: arready=1. AR handshake latches the request. The next cycle drives arready=0, rvalid=1, rid, and rdata for beat 0.
  - R_DATA: on each R handshake, present the next beat in the following cycle. rlast=1 on beat len. The handshake on rlast returns to R_IDLE.
  - rdata, rresp, rlast are held stable while rvalid && !rready.
- Addressing:
  - word = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8).
  - FIXED: constant address.
  - INCR: addr += 1<<size.
  - WRAP: boundary = (len+1)<<size; the address wraps to the aligned boundary base. len must be 1/3/7/15.
- Errors (SLVERR=2'b10, otherwise OKAY=2'b00):
  - Word outside 0..MEM_DEPTH-1: SLVERR.
  - size > log2(DATA_WIDTH/8): SLVERR.
  - Illegal WRAP len, or burst=2'b11: SLVERR.
  - Erroring read beats return rdata=0 with rresp=SLVERR on that beat only.
  - Erroring write beats do not update memory. bresp is SLVERR if any beat errored (sticky).
  - wlast early (counter<len) or missing at counter==len: burst terminates, bresp=SLVERR.
- Simultaneous read/write to the same word in one cycle: read returns pre-write data. Read and write channels never stall each other.
- One outstanding transaction per direction. No reordering; IDs are echoed.

Decomposition:
- Add to peripheral_axi4_pkg:
  - AXI_RESPONSE_OKAY/EXOKAY/SLVERR/DECERR.
  - AXI_BURST_FIXED/INCR/WRAP as enum burst_t.
  - Write and read FSM state enums.
- Sub-module peripheral_bfm_axi4_addr_gen: combinational next-address and error calculation from (addr, size, len, burst). Instantiated once per channel.

Test Plan:
- Reset release: awready=arready=1 one cycle after aresetn rises; all other outputs 0.
- Single write then read:
  - AW addr 0x10, len 0, size 2, data 0xDEADBEEF, wstrb 0xF, then AR 0x10.
  - Expect rdata 0xDEADBEEF, rresp 0, rlast 1, bid/rid echo 0x5.
- INCR burst:
  - Write len 3 at 0x20 with data 1..4, then read back len 3.
  - Expect 1,2,3,4 with rlast only on beat 4.
  - Repeat with rready toggled each cycle; rdata stays stable while stalled.
- WRAP burst:
  - len 3, size 2, start 0x38; expect accesses to 0x38, 0x3C, 0x30, 0x34.
  - Write-then-read matches in that address order.
- Strobes: write 0xFFFFFFFF, then 0x11223344 with wstrb 0b0101; read expects 0xFF22FF44.
- Errors:
  - Out-of-range address returns SLVERR and rdata 0, with memory unchanged.
  - Early wlast on a len 3 burst gives bresp=SLVERR after beat 2.
  - Assert aresetn=0 mid-read burst; rvalid=0 next cycle; a new read succeeds afterwards.

Source files
------------

// File: rtl/peripheral_axi4_pkg.sv
// peripheral_axi4_pkg: shared AXI4 response codes, burst types and BFM FSM states.
package peripheral_axi4_pkg;

    localparam logic [1:0] AXI_RESPONSE_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESPONSE_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESPONSE_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESPONSE_DECERR = 2'b11;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/peripheral_bfm_axi4_addr_gen.sv
// peripheral_bfm_axi4_addr_gen: word index, beat error and next beat address for one AXI4 burst beat.
module peripheral_bfm_axi4_addr_gen
    import peripheral_axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int WORD_W     = $clog2(MEM_DEPTH),
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic [WORD_W-1:0]     word_o,
    output logic                  err_o
);
    localparam int LANE_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] off, word, bytes, incr, bound, wrap;
    logic                  wrap_len_ok;

    always_comb begin
        off         = addr_i - BASE_ADDR;
        word        = off >> LANE_LOG2;
        bytes       = ONE << size_i;
        incr        = (addr_i & ~(bytes - ONE)) + bytes;
        // wrap window is the whole burst, aligned to its own size
        bound       = (ADDR_WIDTH'(len_i) + ONE) << size_i;
        wrap        = (addr_i & ~(bound - ONE)) | (incr & (bound - ONE));
        wrap_len_ok = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
        next_addr_o = burst_i == AXI_BURST_FIXED ? addr_i :
                      burst_i == AXI_BURST_WRAP  ? wrap : incr;
        word_o      = word[WORD_W-1:0];
        err_o       = addr_i < BASE_ADDR || word >= ADDR_WIDTH'(MEM_DEPTH) ||
                      size_i > 3'(LANE_LOG2) || burst_i == 2'b11 ||
                      (burst_i == AXI_BURST_WRAP && !wrap_len_ok);
    end

endmodule

// File: rtl/peripheral_bfm_slave_mem_axi4.sv
// peripheral_bfm_slave_mem_axi4: AXI4 slave memory BFM with independent write and read burst FSMs
// over one word array; supports FIXED/INCR/WRAP, byte strobes, ID echo and SLVERR responses.
module peripheral_bfm_slave_mem_axi4
    import peripheral_axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WORD_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d, bid_q;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next;
    logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d, bresp_q;
    logic                  w_err_q, w_err_d, awready_q, wready_q, bvalid_q;
    logic [WORD_W-1:0]     w_word;
    logic                  w_beat_err, w_fire, w_end;

    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] r_nxt_q, r_nxt_d, r_gen_addr, r_gen_next;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_gen_len;
    logic [2:0]            r_size_q, r_size_d, r_gen_size;
    logic [1:0]            r_burst_q, r_burst_d, r_gen_burst, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d, arready_q, rvalid_q;
    logic [WORD_W-1:0]     r_word;
    logic                  r_beat_err, ar_fire, r_fire, r_load;

    peripheral_bfm_axi4_addr_gen #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH),
        .WORD_W(WORD_W), .BASE_ADDR(BASE_ADDR)
    ) u_w_gen (
        .addr_i(w_addr_q), .size_i(aw_size_q), .len_i(aw_len_q), .burst_i(aw_burst_q),
        .next_addr_o(w_next), .word_o(w_word), .err_o(w_beat_err)
    );

    // in idle the read generator looks at the incoming AR so beat 0 is ready one cycle later
    assign r_gen_addr  = r_state_q == R_IDLE ? araddr_i  : r_nxt_q;
    assign r_gen_size  = r_state_q == R_IDLE ? arsize_i  : r_size_q;
    assign r_gen_len   = r_state_q == R_IDLE ? arlen_i   : r_len_q;
    assign r_gen_burst = r_state_q == R_IDLE ? arburst_i : r_burst_q;

    peripheral_bfm_axi4_addr_gen #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH),
        .WORD_W(WORD_W), .BASE_ADDR(BASE_ADDR)
    ) u_r_gen (
        .addr_i(r_gen_addr), .size_i(r_gen_size), .len_i(r_gen_len), .burst_i(r_gen_burst),
        .next_addr_o(r_gen_next), .word_o(r_word), .err_o(r_beat_err)
    );

    assign w_fire = aresetn && w_state_q == W_DATA && wvalid_i && wready_q;
    assign w_end  = w_cnt_q == aw_len_q;

    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        w_addr_d   = w_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        case (w_state_q)
            W_IDLE: if (awvalid_i && awready_q) begin
                aw_id_d    = awid_i;
                w_addr_d   = awaddr_i;
                aw_len_d   = awlen_i;
                aw_size_d  = awsize_i;
                aw_burst_d = awburst_i;
                w_cnt_d    = '0;
                w_err_d    = 1'b0;
                w_state_d  = W_DATA;
            end
            W_DATA: if (w_fire) begin
                w_addr_d = w_next;
                w_cnt_d  = w_cnt_q + 8'd1;
                // a wlast that disagrees with the beat count is a protocol error
                w_err_d  = w_err_q | w_beat_err | (wlast_i != w_end);
                if (wlast_i || w_end) w_state_d = W_RESP;
            end
            W_RESP: if (bready_i && bvalid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            w_addr_q   <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= AXI_RESPONSE_OKAY;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            w_addr_q   <= w_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            awready_q  <= w_state_d == W_IDLE;
            wready_q   <= w_state_d == W_DATA;
            bvalid_q   <= w_state_d == W_RESP;
            if (w_state_q == W_DATA && w_state_d == W_RESP) begin
                bid_q   <= aw_id_q;
                bresp_q <= w_err_d ? AXI_RESPONSE_SLVERR : AXI_RESPONSE_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_fire && !w_beat_err)
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_i[b]) mem_q[w_word][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end

    assign ar_fire = r_state_q == R_IDLE && arvalid_i && arready_q;
    assign r_fire  = r_state_q == R_DATA && rvalid_q && rready_i;
    assign r_load  = ar_fire || (r_fire && !rlast_q);

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_nxt_d   = r_nxt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        if (ar_fire) begin
            rid_d     = arid_i;
            r_len_d   = arlen_i;
            r_size_d  = arsize_i;
            r_burst_d = arburst_i;
            r_cnt_d   = '0;
            r_state_d = R_DATA;
        end
        if (r_fire) begin
            if (rlast_q) r_state_d = R_IDLE;
            else         r_cnt_d   = r_cnt_q + 8'd1;
        end
        // reads sample mem_q before any same-edge write lands
        if (r_load) begin
            rdata_d = r_beat_err ? '0 : mem_q[r_word];
            rresp_d = r_beat_err ? AXI_RESPONSE_SLVERR : AXI_RESPONSE_OKAY;
            rlast_d = r_cnt_d == r_len_d;
            r_nxt_d = r_gen_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_nxt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESPONSE_OKAY;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_nxt_q   <= r_nxt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= r_state_d == R_IDLE;
            rvalid_q  <= r_state_d == R_DATA;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;

endmodule

// File: tb/tb_peripheral_bfm_slave_mem_axi4.sv
// tb_peripheral_bfm_slave_mem_axi4: directed AXI4 transactions against the slave memory BFM,
// checked with immediate assertions against hand-computed values.
module tb_peripheral_bfm_slave_mem_axi4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [31:0] wd [16];
    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_rid, b_id;
    logic [1:0]  b_resp;

    always #5 aclk = ~aclk;

    peripheral_bfm_slave_mem_axi4 dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0: return awready;
            1: return wready;
            2: return bvalid;
            3: return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_for(input int w);
        int n = 0;
        while (sel(w) !== 1'b1 && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        chk($sformatf("handshake_wait_%0d", w), {31'b0, sel(w)}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int nb,
                      input logic lastf, input logic [3:0] strb);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wait_for(0);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wdata = wd[i]; wstrb = strb; wlast = lastf && (i == nb - 1); wvalid = 1'b1;
            wait_for(1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        wait_for(2);
        b_id = bid; b_resp = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        wait_for(3);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic r_beats(input int nb, input bit stall);
        for (int i = 0; i < nb; i++) begin
            wait_for(4);
            got_data[i] = rdata; got_resp[i] = rresp; got_last[i] = rlast; got_rid = rid;
            if (stall) begin
                @(posedge aclk); #1;
                chk("stall_rvalid", {31'b0, rvalid}, 32'd1);
                chk("stall_rdata_hold", rdata, got_data[i]);
            end
            rready = 1'b1;
            @(posedge aclk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input bit stall);
        ar_req(id, addr, len, size, burst);
        r_beats(int'(len) + 1, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ctrl", {26'b0, awready, wready, bvalid, arready, rvalid, rlast}, 32'd0);
        chk("rst_resp_ids", {20'b0, bresp, rresp, bid, rid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_ready", {30'b0, awready, arready}, 32'd3);
        chk("post_rst_idle", {29'b0, wready, bvalid, rvalid}, 32'd0);

        // single beat write then read
        wd[0] = 32'hDEADBEEF;
        wr(4'h5, 32'h10, 8'd0, 3'd2, 2'b01, 1, 1'b1, 4'hF);
        chk("single_bid", {28'b0, b_id}, 32'h5);
        chk("single_bresp", {30'b0, b_resp}, 32'h0);
        rd(4'h5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("single_rdata", got_data[0], 32'hDEADBEEF);
        chk("single_rresp", {30'b0, got_resp[0]}, 32'h0);
        chk("single_rlast", {31'b0, got_last[0]}, 32'd1);
        chk("single_rid", {28'b0, got_rid}, 32'h5);

        // INCR burst, then read back free-running and stalled
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        wr(4'h3, 32'h20, 8'd3, 3'd2, 2'b01, 4, 1'b1, 4'hF);
        chk("incr_bresp", {30'b0, b_resp}, 32'h0);
        chk("incr_bid", {28'b0, b_id}, 32'h3);
        rd(4'hA, 32'h20, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_rdata_%0d", i), got_data[i], 32'(i + 1));
            chk($sformatf("incr_rlast_%0d", i), {31'b0, got_last[i]}, {31'b0, i == 3});
        end
        chk("incr_rid", {28'b0, got_rid}, 32'hA);
        rd(4'hB, 32'h20, 8'd3, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_rdata_%0d", i), got_data[i], 32'(i + 1));
            chk($sformatf("stall_rlast_%0d", i), {31'b0, got_last[i]}, {31'b0, i == 3});
        end

        // WRAP from 0x38 touches 0x38, 0x3C, 0x30, 0x34
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        wr(4'h6, 32'h38, 8'd3, 3'd2, 2'b10, 4, 1'b1, 4'hF);
        chk("wrap_bresp", {30'b0, b_resp}, 32'h0);
        rd(4'h6, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0);
        chk("wrap_mem_30", got_data[0], 32'hA2);
        chk("wrap_mem_34", got_data[1], 32'hA3);
        chk("wrap_mem_38", got_data[2], 32'hA0);
        chk("wrap_mem_3c", got_data[3], 32'hA1);
        rd(4'h7, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_rdata_%0d", i), got_data[i], 32'hA0 + 32'(i));

        // byte strobes
        wd[0] = 32'hFFFFFFFF;
        wr(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 1, 1'b1, 4'hF);
        wd[0] = 32'h11223344;
        wr(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 1, 1'b1, 4'b0101);
        rd(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("strb_rdata", got_data[0], 32'hFF22FF44);

        // out-of-range access; word 256 would alias word 0 if it leaked through
        wd[0] = 32'hCAFE0000;
        wr(4'h2, 32'h0, 8'd0, 3'd2, 2'b01, 1, 1'b1, 4'hF);
        wd[0] = 32'h12345678;
        wr(4'h2, 32'h400, 8'd0, 3'd2, 2'b01, 1, 1'b1, 4'hF);
        chk("oor_bresp", {30'b0, b_resp}, 32'h2);
        rd(4'h2, 32'h400, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("oor_rresp", {30'b0, got_resp[0]}, 32'h2);
        chk("oor_rdata", got_data[0], 32'h0);
        rd(4'h2, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("oor_mem_unchanged", got_data[0], 32'hCAFE0000);

        // illegal size and reserved burst type
        rd(4'h4, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
        chk("size_err_rresp", {30'b0, got_resp[0]}, 32'h2);
        chk("size_err_rdata", got_data[0], 32'h0);
        rd(4'h4, 32'h10, 8'd0, 3'd2, 2'b11, 1'b0);
        chk("burst_err_rresp", {30'b0, got_resp[0]}, 32'h2);

        // early wlast on beat 2 of 4, and missing wlast on a single beat
        wd[0] = 32'h55; wd[1] = 32'h66;
        wr(4'h9, 32'h50, 8'd3, 3'd2, 2'b01, 2, 1'b1, 4'hF);
        chk("early_wlast_bresp", {30'b0, b_resp}, 32'h2);
        chk("early_wlast_bid", {28'b0, b_id}, 32'h9);
        chk("early_wlast_awready", {31'b0, awready}, 32'd1);
        wr(4'h8, 32'h54, 8'd0, 3'd2, 2'b01, 1, 1'b0, 4'hF);
        chk("missing_wlast_bresp", {30'b0, b_resp}, 32'h2);

        // reset in the middle of a read burst
        ar_req(4'hC, 32'h20, 8'd3, 3'd2, 2'b01);
        r_beats(1, 1'b0);
        chk("midrst_rvalid_before", {31'b0, rvalid}, 32'd1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("midrst_arready", {31'b0, arready}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        rd(4'hD, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("after_rst_rdata", got_data[0], 32'hDEADBEEF);
        chk("after_rst_rid", {28'b0, got_rid}, 32'hD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
